// File: rtl/cadence_pkg.sv
// ============================================================================
// Module   : cadence_pkg
// Function : Shared constants, BCD converter state type and width helper.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cadence_pkg;

  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] SPM_CLAMP  = 16'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin16_to_bcd4.sv
// ============================================================================
// Module   : bin16_to_bcd4
// Function : Sequential double-dabble, one bit per cycle, 16-bit to 4 BCD digits.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bin16_to_bcd4
  import cadence_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        done
);

  bcd_state_t  r_state;
  bcd_state_t  w_state_next;
  logic [15:0] r_work;
  logic [15:0] r_bin_sh;
  logic [15:0] r_bcd;
  logic [3:0]  r_iter;
  logic [15:0] w_adj;
  logic [31:0] w_shifted;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    assign w_adj[g*4 +: 4] = (r_work[g*4 +: 4] >= 4'd5) ? r_work[g*4 +: 4] + 4'd3
                                                         : r_work[g*4 +: 4];
  end

  assign w_shifted = {w_adj, r_bin_sh} << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (r_iter == 4'd15) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work   <= '0;
      r_bin_sh <= '0;
      r_bcd    <= '0;
      r_iter   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin_sh <= bin;
            r_work   <= '0;
            r_iter   <= '0;
          end
        end
        SHIFT: begin
          {r_work, r_bin_sh} <= w_shifted;
          r_iter             <= r_iter + 4'd1;
          if (r_iter == 4'd15) r_bcd <= w_shifted[31:16];
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/step_cadence_meter.sv
// ============================================================================
// Module   : step_cadence_meter
// Function : Steps-per-minute from a ring of time buckets, binary and BCD out.
//            CADENCE_PARTIAL_BUCKET_EN: live estimate including partial bucket.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module step_cadence_meter
  import cadence_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BUCKET_SEC  = 10,
  parameter int NUM_BUCKETS = 6,
  parameter int BUCKET_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        step_pulse,
  output logic [15:0] spm_bin,
  output logic [15:0] spm_bcd,
  output logic        spm_valid,
  output logic        spm_update
);

  localparam int c_cyc_w  = (clog2(CLK_FREQ_HZ) > 0) ? clog2(CLK_FREQ_HZ) : 1;
  localparam int c_sec_w  = (clog2(BUCKET_SEC) > 0) ? clog2(BUCKET_SEC) : 1;
  localparam int c_ptr_w  = clog2(NUM_BUCKETS);
  localparam int c_fill_w = clog2(NUM_BUCKETS + 1);

  localparam logic [c_cyc_w-1:0]  c_cyc_last = c_cyc_w'(CLK_FREQ_HZ - 1);
  localparam logic [c_sec_w-1:0]  c_sec_last = c_sec_w'(BUCKET_SEC - 1);
  localparam logic [c_ptr_w-1:0]  c_ptr_last = c_ptr_w'(NUM_BUCKETS - 1);
  localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(NUM_BUCKETS);
  localparam logic [c_fill_w-1:0] c_fill_pre = c_fill_w'(NUM_BUCKETS - 1);

  logic [c_cyc_w-1:0]  r_cyc_cnt;
  logic [c_sec_w-1:0]  r_sec_cnt;
  logic [BUCKET_W-1:0] r_cur_cnt;
  logic [BUCKET_W-1:0] r_ring [NUM_BUCKETS];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_fill_w-1:0] r_filled;
  logic [15:0]         r_sum;
  logic [15:0]         r_spm_bin;
  logic                r_valid;
  logic                r_pending;
  logic                r_discard;
  logic                r_hide;

  logic        w_sec_tick;
  logic        w_bucket_end;
  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic        w_done_ok;
  logic [15:0] w_sum_next;
  logic [15:0] w_bin_next;
  logic [15:0] w_operand;
  logic [15:0] w_bcd;

  assign w_sec_tick   = (r_cyc_cnt == c_cyc_last);
  assign w_bucket_end = w_sec_tick && (r_sec_cnt == c_sec_last);
  assign w_sum_next   = r_sum - 16'(r_ring[r_wr_ptr]) + 16'(r_cur_cnt);

  always_comb begin
    w_bin_next = r_spm_bin;
`ifdef CADENCE_PARTIAL_BUCKET_EN
    w_bin_next = w_sum_next;
`else
    if (w_bucket_end) w_bin_next = w_sum_next;
`endif
  end

  assign w_operand = (r_spm_bin > SPM_CLAMP) ? SPM_CLAMP : r_spm_bin;
  assign w_start   = r_pending & ~w_busy & ~clear;
  // A conversion started before a clear still runs to completion; its result is dropped.
  assign w_done_ok = w_done & ~r_discard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc_cnt <= '0;
      r_sec_cnt <= '0;
      r_cur_cnt <= '0;
      for (int i = 0; i < NUM_BUCKETS; i++) r_ring[i] <= '0;
      r_wr_ptr  <= '0;
      r_filled  <= '0;
      r_sum     <= '0;
      r_spm_bin <= '0;
      r_valid   <= 1'b0;
      r_pending <= 1'b0;
      r_discard <= 1'b0;
      r_hide    <= 1'b0;
    end else if (clear) begin
      r_cyc_cnt <= '0;
      r_sec_cnt <= '0;
      r_cur_cnt <= '0;
      for (int i = 0; i < NUM_BUCKETS; i++) r_ring[i] <= '0;
      r_wr_ptr  <= '0;
      r_filled  <= '0;
      r_sum     <= '0;
      r_spm_bin <= '0;
      r_valid   <= 1'b0;
      r_pending <= 1'b0;
      r_discard <= w_busy & ~w_done;
      r_hide    <= 1'b1;
    end else begin
      r_cyc_cnt <= w_sec_tick ? '0 : r_cyc_cnt + 1'b1;
      if (w_sec_tick) r_sec_cnt <= (r_sec_cnt == c_sec_last) ? '0 : r_sec_cnt + 1'b1;

      if (w_bucket_end) begin
        r_ring[r_wr_ptr] <= r_cur_cnt;
        r_sum            <= w_sum_next;
        r_wr_ptr         <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
        if (r_filled != c_fill_max) r_filled <= r_filled + 1'b1;
        if (r_filled == c_fill_pre) r_valid <= 1'b1;
        r_cur_cnt        <= step_pulse ? BUCKET_W'(1) : '0;
      end else if (step_pulse && !(&r_cur_cnt)) begin
        r_cur_cnt <= r_cur_cnt + 1'b1;
      end

      r_spm_bin <= w_bin_next;
      if (w_bin_next != r_spm_bin) r_pending <= 1'b1;
      else if (w_start)            r_pending <= 1'b0;

      if (w_done)    r_discard <= 1'b0;
      if (w_done_ok) r_hide    <= 1'b0;
    end
  end

  bin16_to_bcd4 u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_start),
    .bin     (w_operand),
    .busy    (w_busy),
    .bcd     (w_bcd),
    .done    (w_done)
  );

  assign spm_bin    = r_spm_bin;
  assign spm_valid  = r_valid;
  assign spm_update = w_done_ok;
  assign spm_bcd    = (r_hide && !w_done_ok) ? 16'd0 : w_bcd;

endmodule

`default_nettype wire

// File: tb/tb_step_cadence_meter.sv
// ============================================================================
// Module   : tb_step_cadence_meter
// Function : Directed bench for step_cadence_meter (40-cycle buckets, 6-deep ring).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_step_cadence_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        step_pulse;
  logic [15:0] spm_bin;
  logic [15:0] spm_bcd;
  logic        spm_valid;
  logic        spm_update;

  logic        sat_clear;
  logic        sat_step;
  logic [15:0] sat_bin;
  logic [15:0] sat_bcd;
  logic        sat_valid;
  logic        sat_update;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int base;
  int extra_step;
  int upd_count;
  int upd_snap;
  bit sat_active;
  int bucket_steps [32];

  always #5 clk = ~clk;

  step_cadence_meter #(
    .CLK_FREQ_HZ (4),
    .BUCKET_SEC  (10),
    .NUM_BUCKETS (6),
    .BUCKET_W    (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .step_pulse (step_pulse),
    .spm_bin    (spm_bin),
    .spm_bcd    (spm_bcd),
    .spm_valid  (spm_valid),
    .spm_update (spm_update)
  );

  // Long buckets (320 cycles) so a single bucket can take more than 255 steps.
  step_cadence_meter #(
    .CLK_FREQ_HZ (32),
    .BUCKET_SEC  (10),
    .NUM_BUCKETS (2),
    .BUCKET_W    (8)
  ) u_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (sat_clear),
    .step_pulse (sat_step),
    .spm_bin    (sat_bin),
    .spm_bcd    (sat_bcd),
    .spm_valid  (sat_valid),
    .spm_update (sat_update)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    int rel;
    int off;
    int b;
    rel = cyc - base;
    off = rel % 40;
    b   = rel / 40;
    step_pulse = (cyc == extra_step) || (b < 32 && off[0] && off < 2 * bucket_steps[b]);
    sat_step   = sat_active && (cyc < 300);
    @(posedge clk);
    #1;
    cyc++;
    if (spm_update) upd_count++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check_bucket(input int t_end, input int exp_bin, input logic exp_valid_pre,
                              input logic exp_valid);
    run_to(t_end);
    check_eq("valid_before", spm_valid, exp_valid_pre);
    run_to(t_end + 1);
    check_eq("spm_bin", spm_bin, exp_bin);
    check_eq("valid_after", spm_valid, exp_valid);
    run_to(t_end + 17);
    check_eq("update_early", spm_update, 0);
    run_to(t_end + 18);
    check_eq("update_at_18", spm_update, 1);
    check_eq("spm_bcd", spm_bcd, to_bcd(exp_bin));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    clear      = 1'b0;
    step_pulse = 1'b0;
    sat_clear  = 1'b0;
    sat_step   = 1'b0;
    cyc        = 0;
    base       = 0;
    extra_step = -1;
    upd_count  = 0;
    sat_active = 1'b0;
    for (int i = 0; i < 32; i++) bucket_steps[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_bin", spm_bin, 0);
    check_eq("rst_bcd", spm_bcd, 0);
    check_eq("rst_valid", spm_valid, 0);
    check_eq("rst_update", spm_update, 0);

    for (int i = 0; i < 6; i++) bucket_steps[i] = 5;
    bucket_steps[12] = 3;
    bucket_steps[20] = 5;
    extra_step = 519;
    reset_n = 1'b1;
    cyc = 0;

    // Fill the window at 5 steps per bucket.
    for (int b = 0; b < 6; b++)
      check_bucket(40 * b + 39, 5 * (b + 1), 1'b0, (b == 5));

    // Idle buckets drain the window.
    for (int k = 1; k <= 6; k++)
      check_bucket(239 + 40 * k, 30 - 5 * k, 1'b1, 1'b1);

    // Step coincident with bucket_end lands in the next bucket exactly once.
    check_bucket(519, 3, 1'b1, 1'b1);
    check_bucket(559, 4, 1'b1, 1'b1);
    check_bucket(759, 1, 1'b1, 1'b1);
    check_bucket(799, 0, 1'b1, 1'b1);

    // Clear together with a step, during a conversion.
    run_to(840);
    check_eq("pre_clear_bin", spm_bin, 5);
    run_to(845);
    clear = 1'b1;
    extra_step = 845;
    tick();
    clear = 1'b0;
    check_eq("clr_bin", spm_bin, 0);
    check_eq("clr_bcd", spm_bcd, 0);
    check_eq("clr_valid", spm_valid, 0);
    check_eq("clr_update", spm_update, 0);
    base = 846;
    extra_step = -1;
    for (int i = 0; i < 32; i++) bucket_steps[i] = 0;
    bucket_steps[0] = 2;
    bucket_steps[1] = 4;
    upd_snap = upd_count;
    run_to(875);
    check_eq("clr_no_update", upd_count, upd_snap);
    check_bucket(885, 2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    run_to(926);
    check_eq("pre_rst_bin", spm_bin, 6);
    run_to(930);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_bin", spm_bin, 0);
    check_eq("arst_bcd", spm_bcd, 0);
    check_eq("arst_valid", spm_valid, 0);
    check_eq("arst_update", spm_update, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) bucket_steps[i] = 0;
    bucket_steps[0] = 5;
    extra_step = -1;
    base = 0;
    sat_active = 1'b1;
    reset_n = 1'b1;
    cyc = 0;
    check_bucket(39, 5, 1'b0, 1'b0);

    // 300 steps into one bucket of the long-bucket instance.
    run_to(320);
    check_eq("sat_bin", sat_bin, 255);
    check_eq("sat_valid_early", sat_valid, 0);
    run_to(337);
    check_eq("sat_update", sat_update, 1);
    check_eq("sat_bcd_conv", sat_bcd, 16'h0255);
    run_to(639);
    check_eq("sat_valid_pre", sat_valid, 0);
    run_to(640);
    check_eq("sat_valid", sat_valid, 1);
    check_eq("sat_bin_valid", sat_bin, 255);
    check_eq("sat_bcd_valid", sat_bcd, 16'h0255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_cadence_meter.md
Name: step_cadence_meter

Overview:
- Consumes the step detector's single-cycle step pulse and produces cadence in steps per minute (SPM) for the step-mode display path.
- Counts steps into fixed-length time buckets held in a ring.
- The sum over the last NUM_BUCKETS buckets is the cadence.
- Converts the result to 4-digit BCD with a sequential double-dabble unit, so the display shows decimal SPM.

Parameters:
- CLK_FREQ_HZ, 100000000, clk cycles per second; sets the 1 s prescaler.
- BUCKET_SEC, 10, seconds per bucket.
- NUM_BUCKETS, 6, ring depth, 2..16. BUCKET_SEC*NUM_BUCKETS = 60 in synthesis; benches may shrink the window.
- BUCKET_W, 8, per-bucket counter width; the counter saturates at 2^BUCKET_W-1.

Ports:
- clk, input, 1: system clock. One clock only. reset_n is asynchronous, active-low.
- reset_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous restart of all counters and the ring.
- step_pulse, input, 1: one-cycle pulse per detected step.
- spm_bin, output, 16: window sum (binary).
- spm_bcd, output, 16: {thousands, hundreds, tens, ones} BCD of spm_bin.
- spm_valid, output, 1: high once NUM_BUCKETS buckets have completed since reset/clear.
- spm_update, output, 1: one-cycle pulse when spm_bcd is refreshed.

Behaviour:
- Reset (reset_n low, async): all outputs 0, ring zeroed, all pointers and counters 0, BCD FSM in IDLE.
- Prescaler:
  - cyc_cnt counts 0..CLK_FREQ_HZ-1; the wrap is sec_tick.
  - sec_cnt counts 0..BUCKET_SEC-1 on sec_tick; its wrap is bucket_end (one-cycle strobe).
- Current bucket cur_cnt:
  - step_pulse increments it, saturating at 2^BUCKET_W-1.
- On bucket_end, at cycle T:
  - sum <= sum - ring[wr_ptr] + cur_cnt.
  - ring[wr_ptr] <= cur_cnt.
  - wr_ptr <= (wr_ptr+1) mod NUM_BUCKETS.
  - filled increments, saturating at NUM_BUCKETS.
  - cur_cnt <= step_pulse ? 1 : 0. A coincident step counts in the new bucket and is never lost.
- spm_bin <= sum at T+1.
- spm_valid:
  - Goes high at T+1 of the NUM_BUCKETS-th bucket_end.
  - Stays high until reset or clear.
- Sum width is 16 bits. Maximum is NUM_BUCKETS*(2^BUCKET_W-1) = 1530 at defaults, so there is no overflow. spm_bin is clamped to 9999 before BCD.
- BCD FSM has states IDLE, SHIFT, DONE:
  - IDLE -> SHIFT when spm_bin changes (the cycle after the write). This latches the operand.
  - SHIFT runs 16 iterations, one per cycle: add-3 on nibbles >=5, then shift left.
  - DONE: spm_bcd loads and spm_update pulses for 1 cycle; then return to IDLE.
  - Latency from bucket_end to spm_update is 18 cycles.
  - If spm_bin changes during SHIFT, the FSM finishes the current conversion, then restarts with the newest value. Only one pending request is kept.
- clear (synchronous, has priority over step_pulse and bucket_end in the same cycle):
  - Zeroes ring, sum, cur_cnt, filled, wr_ptr, cyc_cnt and sec_cnt.
  - Drops spm_valid.
  - Forces spm_bin and spm_bcd to 0. spm_update does not pulse.
  - Aborts any BCD conversion in progress.
- Outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: CADENCE_PARTIAL_BUCKET_EN.
- Defined:
  - spm_bin = sum - ring[wr_ptr] + cur_cnt, updated every cycle cur_cnt changes. This is a live estimate that includes the partial bucket.
  - A BCD conversion is requested on every change, subject to the single pending-request rule.
  - spm_valid is unchanged.
- Undefined: spm_bin updates only at bucket_end, as above.

Decomposition:
- Package cadence_pkg holds:
  - BCD_DIGITS=4 and SPM_CLAMP=16'd9999.
  - The BCD FSM state enum (IDLE/SHIFT/DONE).
  - Function clog2 for wr_ptr and filled widths.
- One sub-module, bin16_to_bcd4: the sequential double-dabble FSM.
  - Ports: clk, reset_n, start, bin[15:0], busy, bcd[15:0], done.
- The parent holds the prescaler, ring, running sum, clear logic and request tracking.

Test Plan:
- Params CLK_FREQ_HZ=4, BUCKET_SEC=10, NUM_BUCKETS=6 (bucket = 40 cycles). 5 steps per bucket for 6 buckets:
  - spm_valid rises at T+1 of the 6th bucket_end.
  - spm_bin=30.
  - spm_bcd=16'h0030 with spm_update exactly 18 cycles after bucket_end.
- Continue with 0 steps per bucket: spm_bin decrements 30, 25, 20, 15, 10, 5, 0 on successive bucket_ends. BCD tracks each value.
- step_pulse asserted on the bucket_end cycle: the new bucket's cur_cnt is 1. After the window rolls, the total is conserved (no step lost or double-counted).
- 300 steps in one bucket: the bucket saturates at 255. spm_bin=255 and spm_bcd=16'h0255 once valid.
- clear asserted mid-window together with step_pulse and during SHIFT:
  - All outputs go to 0 next cycle and spm_valid goes low.
  - No spm_update pulse occurs.
  - Counting restarts from cyc_cnt=0.
- reset_n dropped asynchronously mid-SHIFT:
  - Outputs go to 0 immediately.
  - After release, behaviour is identical to a fresh start.
